// File: rtl/handshake_pkg.sv
// Shared definitions for the four-phase single-wire handshake link.
// Used by the transmitter (handshake_tx) and the matching receiver.
//   tx_state_e  : transmitter FSM states
//   rx_state_e  : receiver FSM states
//   sync_lvl_e  : decoded value of a 2-flop synchroniser ({stage1, stage0})
package handshake_pkg;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'b00,
    TX_SEND    = 2'b01,
    TX_RELEASE = 2'b10,
    TX_DONE    = 2'b11
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_RST  = 2'b00,
    RX_IDLE = 2'b01,
    RX_READ = 2'b10,
    RX_DONE = 2'b11
  } rx_state_e;

  typedef enum logic [1:0] {
    LOW     = 2'b00,
    RISING  = 2'b01,
    FALLING = 2'b10,
    HIGH    = 2'b11
  } sync_lvl_e;

endpackage

// File: rtl/handshake_tx_if.sv
// Bundle of the handshake_tx local-side and link-side signals.
//   data_in/in_valid/in_ready : parallel word hand-off from local logic
//   ext_data/ext_valid        : serial bit and strobe towards the receiver
//   ext_wr_ack                : receiver acknowledge (asynchronous)
//   tx_done/busy              : status
//   tx_timeout                : ack watchdog pulse (HANDSHAKE_TX_TIMEOUT_EN only)
// Modports: slave = the transmitter, master = its environment.
interface handshake_tx_if #(
  parameter int unsigned BUFFER_WIDTH = 32
) ();

  logic [BUFFER_WIDTH-1:0] data_in;
  logic                    in_valid;
  logic                    in_ready;
  logic                    ext_data;
  logic                    ext_valid;
  logic                    ext_wr_ack;
  logic                    tx_done;
  logic                    busy;
`ifdef HANDSHAKE_TX_TIMEOUT_EN
  logic                    tx_timeout;

  modport slave (
    input  data_in, in_valid, ext_wr_ack,
    output in_ready, ext_data, ext_valid, tx_done, busy, tx_timeout
  );

  modport master (
    output data_in, in_valid, ext_wr_ack,
    input  in_ready, ext_data, ext_valid, tx_done, busy, tx_timeout
  );
`else
  modport slave (
    input  data_in, in_valid, ext_wr_ack,
    output in_ready, ext_data, ext_valid, tx_done, busy
  );

  modport master (
    output data_in, in_valid, ext_wr_ack,
    input  in_ready, ext_data, ext_valid, tx_done, busy
  );
`endif

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//   clock : destination clock
//   reset : asynchronous active-low reset, clears both stages
//   d     : asynchronous input
//   q     : {stage1, stage0}; both stages exposed so callers can
//           distinguish settled HIGH/LOW from transitions
module sync_2ff (
  input  logic       clock,
  input  logic       reset,
  input  logic       d,
  output logic [1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      q <= {q[0], d};
    end
  end

endmodule

// File: rtl/handshake_tx.sv
// Serial four-phase transmitter: takes a BUFFER_WIDTH-bit word and sends it
// LSB first, one bit per complete ext_valid/ext_wr_ack handshake.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : handshake_tx_if.slave (word hand-off, serial link, status)
// Optional ack watchdog enabled by defining HANDSHAKE_TX_TIMEOUT_EN; it then
// drives bus.tx_timeout and abandons the word after TIMEOUT_CYCLES cycles
// without progress.
module handshake_tx
  import handshake_pkg::*;
#(
  parameter int unsigned BUFFER_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic          clock,
  input  logic          reset,
  handshake_tx_if.slave bus
);

  localparam int unsigned      IDX_W    = $clog2(BUFFER_WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_WIDTH - 1);

  if (BUFFER_WIDTH < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("handshake_tx: BUFFER_WIDTH must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  tx_state_e               state_q, state_d;
  logic [BUFFER_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;
  logic [1:0]              ack_sync;
  logic                    ack_high, ack_low;

  sync_2ff u_ack_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.ext_wr_ack),
    .q     (ack_sync)
  );

  assign ack_high = (sync_lvl_e'(ack_sync) == HIGH);
  assign ack_low  = (sync_lvl_e'(ack_sync) == LOW);

`ifdef HANDSHAKE_TX_TIMEOUT_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ready_d = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        valid_d = 1'b0;
        if (bus.in_valid && ready_q) begin
          shift_d = bus.data_in;
          idx_d   = '0;
          data_d  = bus.data_in[0];
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        // Strobe rises only once ack is settled LOW; an ack already HIGH
        // on entry is consumed as a normal acknowledge.
        if (ack_high) begin
          valid_d = 1'b0;
          state_d = TX_RELEASE;
        end else if (ack_low) begin
          valid_d = 1'b1;
        end
      end
      TX_RELEASE: begin
        valid_d = 1'b0;
        if (ack_low) begin
          if (idx_q == LAST_IDX) begin
            state_d = TX_DONE;
          end else begin
            // Shifting right once per bit keeps the next bit at shift[0],
            // equivalent to indexing the original word at idx+1.
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
            data_d  = shift_d[0];
            state_d = TX_SEND;
          end
        end
      end
      TX_DONE: begin
        done_d  = 1'b1;
        idx_d   = '0;
        state_d = TX_IDLE;
      end
    endcase

`ifdef HANDSHAKE_TX_TIMEOUT_EN
    timeout_d = 1'b0;
    cnt_d     = '0;
    if (state_q == TX_SEND || state_q == TX_RELEASE) begin
      if (cnt_q == CNT_LAST) begin
        state_d   = TX_IDLE;
        valid_d   = 1'b0;
        idx_d     = '0;
        timeout_d = 1'b1;
      end else if (state_d == state_q) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif

    // Ready is registered and only granted after a full IDLE cycle, so the
    // DONE -> IDLE cycle (tx_done high) never accepts a new word.
    ready_d = (state_q == TX_IDLE) && (state_d == TX_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= TX_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

`ifdef HANDSHAKE_TX_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.tx_timeout = timeout_q;
`endif

  assign bus.in_ready  = ready_q;
  assign bus.ext_data  = data_q;
  assign bus.ext_valid = valid_q;
  assign bus.tx_done   = done_q;
  assign bus.busy      = (state_q != TX_IDLE);

endmodule
